// File: rtl/apb_sram_init_seq.sv
// APB3 master that fills and/or verifies a block of APB SRAM words with a fixed pattern.
// Define APB_SRAM_SEQ_ERRCNT_EN to add err_count and run verify to the end of the block after a fail.
module apb_sram_init_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LEN_WIDTH  = 14,
  parameter int unsigned ADDR_STEP  = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  aborted,
`ifdef APB_SRAM_SEQ_ERRCNT_EN
  output logic [LEN_WIDTH:0]    err_count,
`endif
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic                  two_pass_q, two_pass_d;
  logic                  verify_q, verify_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic                  aborted_q, aborted_d;
`ifdef APB_SRAM_SEQ_ERRCNT_EN
  logic [LEN_WIDTH:0]    err_cnt_q, err_cnt_d;
`endif
  logic                  xfer_bad;

  assign xfer_bad = PSLVERR | (verify_q & (PRDATA != pattern_q));

  always_comb begin
    state_d     = state_q;
    two_pass_d  = two_pass_q;
    verify_d    = verify_q;
    base_d      = base_q;
    len_d       = len_q;
    pattern_d   = pattern_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    aborted_d   = aborted_q;
`ifdef APB_SRAM_SEQ_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Mode 11 is reserved and behaves as a plain fill.
          two_pass_d  = (mode == 2'b10);
          verify_d    = (mode == 2'b01);
          base_d      = base_addr;
          len_d       = length;
          pattern_d   = pattern;
          addr_d      = base_addr;
          cnt_d       = length;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          aborted_d   = 1'b0;
`ifdef APB_SRAM_SEQ_ERRCNT_EN
          err_cnt_d   = '0;
`endif
          state_d     = (length == '0) ? StDone : StSetup;
        end
      end
      StSetup: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (PREADY) begin
          addr_d = addr_q + ADDR_WIDTH'(ADDR_STEP);
          cnt_d  = cnt_q - 1'b1;
          if (xfer_bad) begin
            fail_d = 1'b1;
            if (!fail_q) fail_addr_d = addr_q;
`ifdef APB_SRAM_SEQ_ERRCNT_EN
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
`endif
          end
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = StDone;
`ifndef APB_SRAM_SEQ_ERRCNT_EN
          end else if (xfer_bad) begin
            state_d = StDone;
`endif
          end else if (cnt_q == LEN_WIDTH'(1)) begin
            if (two_pass_q && !verify_q) begin
              addr_d   = base_q;
              cnt_d    = len_q;
              verify_d = 1'b1;
              state_d  = StSetup;
            end else begin
              state_d = StDone;
            end
          end else begin
            state_d = StSetup;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= StIdle;
      two_pass_q  <= 1'b0;
      verify_q    <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      pattern_q   <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      aborted_q   <= 1'b0;
`ifdef APB_SRAM_SEQ_ERRCNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      two_pass_q  <= two_pass_d;
      verify_q    <= verify_d;
      base_q      <= base_d;
      len_q       <= len_d;
      pattern_q   <= pattern_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      aborted_q   <= aborted_d;
`ifdef APB_SRAM_SEQ_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign PSEL      = (state_q == StSetup) || (state_q == StAccess);
  assign PENABLE   = (state_q == StAccess);
  assign PWRITE    = PSEL & ~verify_q;
  assign PADDR     = addr_q;
  assign PWDATA    = pattern_q;
  assign busy      = PSEL;
  assign done      = (state_q == StDone);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign aborted   = aborted_q;
`ifdef APB_SRAM_SEQ_ERRCNT_EN
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_apb_sram_init_seq.sv
// Directed bench for apb_sram_init_seq with a small APB slave model and transfer log.
module tb_apb_sram_init_seq;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        start, abort;
  logic [1:0]  mode;
  logic [16:0] base_addr;
  logic [13:0] length;
  logic [31:0] pattern;
  logic        busy, done, fail, aborted;
  logic [16:0] fail_addr;
`ifdef APB_SRAM_SEQ_ERRCNT_EN
  logic [14:0] err_count;
`endif
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [16:0] PADDR;
  logic [31:0] PWDATA, PRDATA;

  // Slave model controls
  int          ws_cfg, ws_cnt;
  logic        hold, bad_en, err_en;
  logic [16:0] bad_addr, err_addr;
  logic [31:0] exp_pat;

  // Monitor state
  int          xfer_total = 0, psel_cnt = 0, done_cnt = 0, stab_err = 0;
  logic [16:0] log_addr [64];
  logic        log_wr   [64];
  logic [31:0] log_wd   [64];
  logic        wait_prev = 1'b0, prev_wr;
  logic [16:0] prev_addr;
  logic [31:0] prev_wd;

  int n_total = 0, n_bad = 0;
  int x0, p0, d0, lat;

  always #5 PCLK = ~PCLK;

  apb_sram_init_seq dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .start     (start),
    .mode      (mode),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .aborted   (aborted),
`ifdef APB_SRAM_SEQ_ERRCNT_EN
    .err_count (err_count),
`endif
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  assign PREADY  = PSEL && PENABLE && !hold && (ws_cnt >= ws_cfg);
  assign PRDATA  = (bad_en && PADDR == bad_addr) ? 32'h0 : exp_pat;
  assign PSLVERR = PREADY && err_en && (PADDR == err_addr);

  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)                 ws_cnt <= 0;
    else if (PSEL && PENABLE)     ws_cnt <= PREADY ? 0 : ws_cnt + 1;
    else                          ws_cnt <= 0;
  end

  always @(negedge PCLK) begin
    if (PSEL) psel_cnt <= psel_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (PSEL && PENABLE && PREADY) begin
      log_addr[xfer_total % 64] <= PADDR;
      log_wr[xfer_total % 64]   <= PWRITE;
      log_wd[xfer_total % 64]   <= PWDATA;
      xfer_total <= xfer_total + 1;
    end
    // A waited ACCESS must hold every APB output until PREADY.
    if (wait_prev && PRESETN &&
        (!(PSEL && PENABLE) || PADDR != prev_addr || PWRITE != prev_wr || PWDATA != prev_wd))
      stab_err <= stab_err + 1;
    wait_prev <= PRESETN && PSEL && PENABLE && !PREADY;
    prev_addr <= PADDR;
    prev_wr   <= PWRITE;
    prev_wd   <= PWDATA;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Pulse start for one cycle; returns in cycle 1 of the sequence.
  task automatic go(input logic [1:0] m, input logic [16:0] b, input logic [13:0] l,
                    input logic [31:0] p);
    x0 = xfer_total;
    p0 = psel_cnt;
    d0 = done_cnt;
    mode = m; base_addr = b; length = l; pattern = p; exp_pat = p;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 1;
    while (!done && l < 300) begin
      tick();
      l++;
    end
    tick();
  endtask

  initial begin
    PRESETN = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; base_addr = '0; length = '0;
    pattern = '0; ws_cfg = 0; hold = 1'b0; bad_en = 1'b0; err_en = 1'b0; bad_addr = '0;
    err_addr = '0; exp_pat = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_apb", {PSEL, PENABLE, PWRITE}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    PRESETN = 1'b1;
    tick();

    // Zero-wait fill of four words
    go(2'b00, 17'h0, 14'd4, 32'hA5A5A5A5);
    wait_done(lat);
    chk("fill_lat", lat, 9);
    chk("fill_nxfer", xfer_total - x0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_addr", log_addr[(x0 + i) % 64], 64'(i * 4));
      chk("fill_wr", log_wr[(x0 + i) % 64], 1);
    end
    chk("fill_wdata", log_wd[(x0 + 3) % 64], 32'hA5A5A5A5);
    chk("fill_fail", fail, 0);
    chk("fill_busy_after", busy, 0);

    // Verify with bad data at address 8
    bad_en = 1'b1; bad_addr = 17'h8;
    go(2'b01, 17'h0, 14'd4, 32'h12345678);
    wait_done(lat);
    chk("ver_fail", fail, 1);
    chk("ver_fail_addr", fail_addr, 17'h8);
    chk("ver_rd", log_wr[x0 % 64], 0);
`ifdef APB_SRAM_SEQ_ERRCNT_EN
    chk("ver_nxfer", xfer_total - x0, 4);
    chk("ver_last_addr", log_addr[(x0 + 3) % 64], 17'hC);
    chk("ver_errcnt", err_count, 1);
    chk("ver_lat", lat, 9);
`else
    chk("ver_nxfer", xfer_total - x0, 3);
    chk("ver_lat", lat, 7);
`endif
    bad_en = 1'b0;

    // PSLVERR during fill
    err_en = 1'b1; err_addr = 17'h44;
    go(2'b00, 17'h40, 14'd3, 32'h0F0F0F0F);
    wait_done(lat);
    chk("slverr_fail", fail, 1);
    chk("slverr_fail_addr", fail_addr, 17'h44);
`ifdef APB_SRAM_SEQ_ERRCNT_EN
    chk("slverr_nxfer", xfer_total - x0, 3);
    chk("slverr_lat", lat, 7);
`else
    chk("slverr_nxfer", xfer_total - x0, 2);
    chk("slverr_lat", lat, 5);
`endif
    err_en = 1'b0;

    // Fill then verify with three wait states per access
    ws_cfg = 3;
    go(2'b10, 17'h100, 14'd2, 32'hCAFEF00D);
    wait_done(lat);
    chk("fv_lat", lat, 21);
    chk("fv_nxfer", xfer_total - x0, 4);
    chk("fv_ops", {log_wr[x0 % 64], log_wr[(x0 + 1) % 64], log_wr[(x0 + 2) % 64],
                   log_wr[(x0 + 3) % 64]}, 4'b1100);
    chk("fv_addr2", log_addr[(x0 + 2) % 64], 17'h100);
    chk("fv_addr3", log_addr[(x0 + 3) % 64], 17'h104);
    chk("fv_done_once", done_cnt - d0, 1);
    chk("fv_fail", fail, 0);
    ws_cfg = 0;

    // Zero length
    go(2'b00, 17'h10, 14'd0, 32'h1);
    wait_done(lat);
    chk("len0_lat", lat, 1);
    chk("len0_psel", psel_cnt - p0, 0);

    // Address wrap, reserved mode behaves as fill
    go(2'b11, 17'h1FFFC, 14'd2, 32'h5A5A5A5A);
    wait_done(lat);
    chk("wrap_lat", lat, 5);
    chk("wrap_addr0", log_addr[x0 % 64], 17'h1FFFC);
    chk("wrap_addr1", log_addr[(x0 + 1) % 64], 17'h0);
    chk("wrap_wr", log_wr[(x0 + 1) % 64], 1);

    // Abort in SETUP
    go(2'b00, 17'h0, 14'd4, 32'h3);
    abort = 1'b1;
    wait_done(lat);
    abort = 1'b0;
    chk("abs_lat", lat, 2);
    chk("abs_aborted", aborted, 1);
    chk("abs_nxfer", xfer_total - x0, 0);

    // Abort while ACCESS is stalled; start during busy is ignored
    hold = 1'b1;
    go(2'b01, 17'h20, 14'd4, 32'h77);
    tick();
    abort = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("aba_busy", busy, 1);
    chk("aba_access", {PSEL, PENABLE}, 2'b11);
    chk("aba_not_yet", aborted, 0);
    tick();
    hold = 1'b0;
    tick();
    chk("aba_done", done, 1);
    chk("aba_aborted", aborted, 1);
    abort = 1'b0;
    repeat (4) tick();
    chk("aba_idle", busy, 0);
    chk("aba_nxfer", xfer_total - x0, 1);
    chk("aba_done_once", done_cnt - d0, 1);
    chk("aba_fail", fail, 0);

    // Reset during ACCESS, then a normal run
    ws_cfg = 3;
    go(2'b00, 17'h0, 14'd4, 32'h9);
    tick();
    tick();
    PRESETN = 1'b0;
    #1;
    chk("rstm_apb", {PSEL, PENABLE}, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_fail", fail, 0);
    tick();
    PRESETN = 1'b1;
    ws_cfg = 0;
    tick();
    go(2'b00, 17'h80, 14'd1, 32'hBEEF);
    wait_done(lat);
    chk("rstm_lat", lat, 3);
    chk("rstm_nxfer", xfer_total - x0, 1);
    chk("rstm_addr", log_addr[x0 % 64], 17'h80);

    chk("apb_stable", stab_err, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
